// File: rtl/mor1kx_tlb_reload_bridge.sv
// TLB-reload bridge: arbitrates IMMU/DMMU page-table reads onto a dedicated
// Wishbone classic master and returns each read word to the winning MMU.
module mor1kx_tlb_reload_bridge #(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_TLB_RELOAD_TIMEOUT = 255
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            immu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
    output logic                            immu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,

    input  logic                            dmmu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
    output logic                            dmmu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,

    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_stb_o,
    output logic                            wbm_we_o,
    output logic [3:0]                      wbm_sel_o,
    output logic [2:0]                      wbm_cti_o,
    output logic [1:0]                      wbm_bte_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i,

    output logic                            busy_o,
    output logic                            bus_error_o,
    output logic [1:0]                      fsm_state
);

    localparam int W = OPTION_OPERAND_WIDTH;
    localparam logic [15:0] TIMEOUT    = 16'(OPTION_TLB_RELOAD_TIMEOUT);
    localparam bit          TIMEOUT_EN = (OPTION_TLB_RELOAD_TIMEOUT != 0);
    localparam logic [W-1:0] ADDR_MASK = {{(W-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        grant_dmmu;
    logic        last_dmmu;
    logic [15:0] tmo_cnt;
    logic        cyc;
    logic        pick_dmmu;
    logic [W-1:0] pick_addr;
    logic        timed_out;

    // Handshake: each req_i is a level held until its ack_o pulse; ack_o is
    // a single-cycle strobe with data_o valid in that cycle. On the bus,
    // cyc/stb stay high until the first ack/err (or timeout) terminates it.
    always_comb begin
        pick_dmmu = dmmu_req_i;
        if (immu_req_i && dmmu_req_i)
            pick_dmmu = ~last_dmmu;
        pick_addr = pick_dmmu ? dmmu_addr_i : immu_addr_i;
    end

    assign timed_out = TIMEOUT_EN && (tmo_cnt == TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant_dmmu  <= 1'b0;
            last_dmmu   <= 1'b1;
            tmo_cnt     <= 16'd0;
            cyc         <= 1'b0;
            wbm_adr_o   <= '0;
            immu_data_o <= '0;
            dmmu_data_o <= '0;
            immu_ack_o  <= 1'b0;
            dmmu_ack_o  <= 1'b0;
            bus_error_o <= 1'b0;
        end else begin
            immu_ack_o  <= 1'b0;
            dmmu_ack_o  <= 1'b0;
            bus_error_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (immu_req_i || dmmu_req_i) begin
                        grant_dmmu <= pick_dmmu;
                        wbm_adr_o  <= pick_addr & ADDR_MASK;
                        cyc        <= 1'b1;
                        tmo_cnt    <= 16'd0;
                        state      <= BUS;
                    end
                end
                BUS: begin
                    // ack takes priority over err when both arrive together
                    if (wbm_ack_i) begin
                        cyc <= 1'b0;
                        if (grant_dmmu) begin
                            dmmu_data_o <= wbm_dat_i;
                            dmmu_ack_o  <= 1'b1;
                        end else begin
                            immu_data_o <= wbm_dat_i;
                            immu_ack_o  <= 1'b1;
                        end
                        state <= RESP;
                    end else if (wbm_err_i || timed_out) begin
                        // a zero word steers the MMU into its pagefault path
                        cyc         <= 1'b0;
                        bus_error_o <= 1'b1;
                        if (grant_dmmu) begin
                            dmmu_data_o <= '0;
                            dmmu_ack_o  <= 1'b1;
                        end else begin
                            immu_data_o <= '0;
                            immu_ack_o  <= 1'b1;
                        end
                        state <= RESP;
                    end else if (tmo_cnt != 16'hffff) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                RESP: begin
                    last_dmmu <= grant_dmmu;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wbm_cyc_o = cyc;
    assign wbm_stb_o = cyc;
    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = 4'hf;
    assign wbm_cti_o = 3'b000;
    assign wbm_bte_o = 2'b00;
    assign busy_o    = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_mor1kx_tlb_reload_bridge.sv
// Directed bench for the TLB-reload bridge: vector table of single reloads
// plus sequences for two-level walks, round robin, reset and timeout.
module tb_mor1kx_tlb_reload_bridge;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (timeout = 4) ----------------
    logic         immu_req = 1'b0, dmmu_req = 1'b0;
    logic [W-1:0] immu_addr = '0, dmmu_addr = '0;
    logic         immu_ack, dmmu_ack;
    logic [W-1:0] immu_data, dmmu_data;
    logic [W-1:0] wbm_adr;
    logic         wbm_cyc, wbm_stb, wbm_we;
    logic [3:0]   wbm_sel;
    logic [2:0]   wbm_cti;
    logic [1:0]   wbm_bte;
    logic [W-1:0] wbm_dat = '0;
    logic         wbm_ack = 1'b0, wbm_err = 1'b0;
    logic         busy, bus_error;
    logic [1:0]   fsm_state;

    mor1kx_tlb_reload_bridge #(
        .OPTION_OPERAND_WIDTH(W),
        .OPTION_TLB_RELOAD_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .immu_req_i(immu_req), .immu_addr_i(immu_addr),
        .immu_ack_o(immu_ack), .immu_data_o(immu_data),
        .dmmu_req_i(dmmu_req), .dmmu_addr_i(dmmu_addr),
        .dmmu_ack_o(dmmu_ack), .dmmu_data_o(dmmu_data),
        .wbm_adr_o(wbm_adr), .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb),
        .wbm_we_o(wbm_we), .wbm_sel_o(wbm_sel), .wbm_cti_o(wbm_cti),
        .wbm_bte_o(wbm_bte), .wbm_dat_i(wbm_dat),
        .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err),
        .busy_o(busy), .bus_error_o(bus_error), .fsm_state(fsm_state)
    );

    // ---------------- second DUT (timeout disabled) ----------------
    logic         d0_ireq = 1'b0;
    logic [W-1:0] d0_iaddr = 32'h0000_0800;
    logic         d0_dreq = 1'b0;
    logic [W-1:0] d0_daddr = '0;
    logic         d0_iack, d0_dack;
    logic [W-1:0] d0_idata, d0_ddata;
    logic [W-1:0] d0_adr;
    logic         d0_cyc, d0_stb, d0_we;
    logic [3:0]   d0_sel;
    logic [2:0]   d0_cti;
    logic [1:0]   d0_bte;
    logic [W-1:0] d0_dat = '0;
    logic         d0_wack = 1'b0, d0_werr = 1'b0;
    logic         d0_busy, d0_berr;
    logic [1:0]   d0_state;

    mor1kx_tlb_reload_bridge #(
        .OPTION_OPERAND_WIDTH(W),
        .OPTION_TLB_RELOAD_TIMEOUT(0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .immu_req_i(d0_ireq), .immu_addr_i(d0_iaddr),
        .immu_ack_o(d0_iack), .immu_data_o(d0_idata),
        .dmmu_req_i(d0_dreq), .dmmu_addr_i(d0_daddr),
        .dmmu_ack_o(d0_dack), .dmmu_data_o(d0_ddata),
        .wbm_adr_o(d0_adr), .wbm_cyc_o(d0_cyc), .wbm_stb_o(d0_stb),
        .wbm_we_o(d0_we), .wbm_sel_o(d0_sel), .wbm_cti_o(d0_cti),
        .wbm_bte_o(d0_bte), .wbm_dat_i(d0_dat),
        .wbm_ack_i(d0_wack), .wbm_err_i(d0_werr),
        .busy_o(d0_busy), .bus_error_o(d0_berr), .fsm_state(d0_state)
    );

    // ---------------- Wishbone slave model ----------------
    // mode: 0 ack, 1 err, 2 silent, 3 ack+err together
    int           slave_mode = 2;
    int           slave_wait = 0;
    int           wcnt = 0;
    logic [W-1:0] slave_dat = '0;
    logic [W-1:0] read_log[$];

    always @(posedge clk) begin
        #1;
        wbm_dat = slave_dat;
        if (wbm_cyc && wbm_stb) begin
            if (slave_mode != 2 && wcnt == slave_wait) begin
                wbm_ack = (slave_mode == 0 || slave_mode == 3);
                wbm_err = (slave_mode == 1 || slave_mode == 3);
                read_log.push_back(wbm_adr);
            end else begin
                wbm_ack = 1'b0;
                wbm_err = 1'b0;
            end
            wcnt++;
        end else begin
            wbm_ack = 1'b0;
            wbm_err = 1'b0;
            wcnt = 0;
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_idata = '0;
    logic [W-1:0] exp_ddata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         ireq;
        logic [W-1:0] iaddr;
        logic         dreq;
        logic [W-1:0] daddr;
        int           mode;
        int           waits;
        logic [W-1:0] rdata;
        logic         exp_d;
        logic [W-1:0] exp_adr;
        logic [W-1:0] exp_data;
        int           exp_berr;
        int           exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int idx, input vec_t v);
        int           lat = 0;
        int           cyc_n = 0;
        int           berr_n = 0;
        int           both_n = 0;
        logic         done = 1'b0;
        logic         got_d = 1'b0;
        logic [W-1:0] seen_adr = '0;
        logic [W-1:0] got_data = '0;
        @(negedge clk);
        slave_mode = v.mode;
        slave_wait = v.waits;
        slave_dat  = v.rdata;
        immu_req   = v.ireq;
        immu_addr  = v.iaddr;
        dmmu_req   = v.dreq;
        dmmu_addr  = v.daddr;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (wbm_cyc && wbm_stb) begin
                if (cyc_n == 0) seen_adr = wbm_adr;
                cyc_n++;
            end
            if (bus_error) berr_n++;
            if (immu_ack && dmmu_ack) both_n++;
            if (immu_ack || dmmu_ack) begin
                done     = 1'b1;
                got_d    = dmmu_ack;
                got_data = dmmu_ack ? dmmu_data : immu_data;
            end
        end
        immu_req = 1'b0;
        dmmu_req = 1'b0;
        if (v.exp_d) exp_ddata = v.exp_data;
        else         exp_idata = v.exp_data;
        check($sformatf("v%0d ack_seen", idx), 32'(done), 32'd1);
        check($sformatf("v%0d port", idx), 32'(got_d), 32'(v.exp_d));
        check($sformatf("v%0d data", idx), got_data, v.exp_data);
        check($sformatf("v%0d adr", idx), seen_adr, v.exp_adr);
        check($sformatf("v%0d bus_error_pulses", idx), 32'(berr_n), 32'(v.exp_berr));
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d cyc_cycles", idx), 32'(cyc_n), 32'(v.exp_lat - 1));
        check($sformatf("v%0d both_acks", idx), 32'(both_n), 32'd0);
        @(negedge clk);
        check($sformatf("v%0d busy_after", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d acks_after", idx), 32'({immu_ack, dmmu_ack}), 32'd0);
        check($sformatf("v%0d immu_data_hold", idx), immu_data, exp_idata);
        check($sformatf("v%0d dmmu_data_hold", idx), dmmu_data, exp_ddata);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    int   n_ack;
    int   hi;
    int   ack_t[4];
    logic ack_p[4];

    initial begin
        //             ireq  iaddr          dreq  daddr          mode wt rdata          exp_d exp_adr        exp_data       berr lat
        vecs[0] = '{1'b1, 32'h0010_2004, 1'b0, 32'h0,         0, 0, 32'hABCD_E400, 1'b0, 32'h0010_2004, 32'hABCD_E400, 0, 2};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 32'h0000_8003, 0, 1, 32'h1234_5678, 1'b1, 32'h0000_8000, 32'h1234_5678, 0, 3};
        vecs[2] = '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 0, 0, 32'hCAFE_0001, 1'b0, 32'h0000_0100, 32'hCAFE_0001, 0, 2};
        vecs[3] = '{1'b1, 32'h0000_0104, 1'b1, 32'h0000_0204, 0, 0, 32'h0BAD_F00D, 1'b1, 32'h0000_0204, 32'h0BAD_F00D, 0, 2};
        vecs[4] = '{1'b0, 32'h0,         1'b1, 32'h0000_0300, 1, 0, 32'hDEAD_BEEF, 1'b1, 32'h0000_0300, 32'h0,         1, 2};
        vecs[5] = '{1'b1, 32'h0000_0400, 1'b1, 32'h0000_0500, 2, 0, 32'h7777_7777, 1'b0, 32'h0000_0400, 32'h0,         1, 6};
        vecs[6] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,         0, 3, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 0, 5};
        vecs[7] = '{1'b1, 32'h0000_0600, 1'b1, 32'h0000_0700, 3, 0, 32'h55AA_33CC, 1'b1, 32'h0000_0700, 32'h55AA_33CC, 0, 2};

        // reset values
        repeat (2) @(negedge clk);
        check("rst immu_ack", 32'(immu_ack), 32'd0);
        check("rst dmmu_ack", 32'(dmmu_ack), 32'd0);
        check("rst immu_data", immu_data, 32'd0);
        check("rst dmmu_data", dmmu_data, 32'd0);
        check("rst wbm_adr", wbm_adr, 32'd0);
        check("rst cyc_stb_we", 32'({wbm_cyc, wbm_stb, wbm_we}), 32'd0);
        check("rst wbm_sel", 32'(wbm_sel), 32'hf);
        check("rst cti_bte", 32'({wbm_cti, wbm_bte}), 32'd0);
        check("rst busy_berr", 32'({busy, bus_error}), 32'd0);
        check("rst state", 32'(fsm_state), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // two-level walk: IMMU keeps req and moves its address at the first ack
        @(negedge clk);
        read_log.delete();
        slave_mode = 0; slave_wait = 0; slave_dat = 32'h0000_2001;
        immu_addr = 32'h0000_0100; immu_req = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 40 && n_ack < 2; c++) begin
            @(negedge clk);
            if (immu_ack) begin
                n_ack++;
                if (n_ack == 1) immu_addr = 32'h0000_2008;
                else immu_req = 1'b0;
            end
        end
        immu_req = 1'b0;
        repeat (4) @(negedge clk);
        check("walk immu_acks", 32'(n_ack), 32'd2);
        check("walk read_count", 32'(read_log.size()), 32'd2);
        if (read_log.size() >= 2) begin
            check("walk read0", read_log[0], 32'h0000_0100);
            check("walk read1", read_log[1], 32'h0000_2008);
        end

        // round robin, both requesting from reset, 2 wait states
        @(negedge clk);
        rst = 1'b1;
        immu_addr = 32'h0000_1000; dmmu_addr = 32'h0000_2000;
        immu_req = 1'b1; dmmu_req = 1'b1;
        slave_mode = 0; slave_wait = 2; slave_dat = 32'h0000_0C01;
        @(negedge clk);
        rst = 1'b0;
        n_ack = 0;
        for (int c = 1; c <= 60 && n_ack < 4; c++) begin
            @(negedge clk);
            if (immu_ack || dmmu_ack) begin
                ack_t[n_ack] = c;
                ack_p[n_ack] = dmmu_ack;
                n_ack++;
                if (n_ack == 4) begin
                    immu_req = 1'b0;
                    dmmu_req = 1'b0;
                end
            end
        end
        check("rr ack_count", 32'(n_ack), 32'd4);
        check("rr first_ack_cycle", 32'(ack_t[0]), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("rr grant%0d", k), 32'(ack_p[k]), 32'(k % 2));
        for (int k = 1; k < 4; k++)
            check($sformatf("rr spacing%0d", k), 32'(ack_t[k] - ack_t[k-1]), 32'd5);
        repeat (2) @(negedge clk);

        // reset asserted while a read is outstanding
        slave_mode = 2;
        immu_addr = 32'h0000_4440; immu_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rstbus cyc_before", 32'(wbm_cyc), 32'd1);
        rst = 1'b1;
        #1;
        check("rstbus cyc_stb_busy", 32'({wbm_cyc, wbm_stb, busy}), 32'd0);
        n_ack = 0;
        repeat (2) begin
            @(negedge clk);
            if (immu_ack || dmmu_ack) n_ack++;
        end
        check("rstbus no_ack", 32'(n_ack), 32'd0);
        read_log.delete();
        slave_mode = 0; slave_wait = 0; slave_dat = 32'h1357_9BDF;
        rst = 1'b0;
        hi = 0;
        n_ack = 0;
        for (int c = 1; c <= 10 && n_ack == 0; c++) begin
            @(negedge clk);
            if (immu_ack) begin
                n_ack = 1;
                hi = c;
                check("rstbus after_data", immu_data, 32'h1357_9BDF);
            end
        end
        immu_req = 1'b0;
        check("rstbus after_ack", 32'(n_ack), 32'd1);
        check("rstbus after_latency", 32'(hi), 32'd2);
        check("rstbus after_adr", (read_log.size() > 0) ? read_log[0] : 32'hFFFF_FFFF, 32'h0000_4440);
        repeat (2) @(negedge clk);

        // timeout disabled: an unanswered read holds the bus indefinitely
        d0_ireq = 1'b1;
        @(negedge clk);
        hi = 0;
        n_ack = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (d0_cyc && d0_stb) hi++;
            if (d0_iack || d0_dack || d0_berr) n_ack++;
        end
        check("notmo cyc_cycles", 32'(hi), 32'd1000);
        check("notmo no_ack", 32'(n_ack), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
